alu_issue_ctrl: RTL and testbench

Sequential front-end for the 16-bit combinational ALU. It accepts operation requests over a valid/ready command channel and drives opcode and operands into the ALU. It waits an opcode-dependent settle time, then captures the result and flags and returns them over a valid/ready response channel. It also holds the architectural NZCV status register that the combinational ALU does not keep.

---
 rtl/alu_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/capture front-end for the 16-bit combinational ALU: one operation in flight,
// opcode-dependent settle time, valid/ready command and response channels, NZCV register.
module alu_issue_ctrl #(
  parameter int WIDTH     = 16,
  parameter int LAT_BASIC = 1,
  parameter int LAT_MUL   = 2,
  parameter int LAT_DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_x,
  input  logic [WIDTH-1:0] cmd_y,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_div_invalid,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_r,
  output logic             resp_err,
  output logic [3:0]       flags,
  input  logic             flags_clr
);

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [4:0]         aluOp_q;
  logic [WIDTH-1:0]   aluX_q;
  logic [WIDTH-1:0]   aluY_q;
  logic [WIDTH-1:0]   respR_q;
  logic               respErr_q;
  logic [3:0]         flags_q;

  logic [CNT_W-1:0]   cmdLat_d;
  logic [WIDTH-1:0]   respR_d;
  logic               respErr_d;
  logic               flagsUpd_d;

  function automatic logic opDefined(input logic [4:0] op);
    return op inside {[5'd0:5'd14], [5'd24:5'd27]};
  endfunction

  // Undefined opcodes still spend one WAIT cycle so their response appears after edge t+1.
  always_comb begin
    cmdLat_d = CNT_W'(LAT_BASIC);
    if (!opDefined(cmd_opcode))
      cmdLat_d = CNT_W'(1);
    else if (cmd_opcode == 5'b00011 || cmd_opcode == 5'b00100)
      cmdLat_d = CNT_W'(LAT_MUL);
    else if (cmd_opcode == 5'b01101 || cmd_opcode == 5'b01110)
      cmdLat_d = CNT_W'(LAT_DIV);
  end

  always_comb begin
    respR_d    = alu_r;
    respErr_d  = 1'b0;
    flagsUpd_d = 1'b1;
    if (!opDefined(aluOp_q)) begin
      respR_d    = '0;
      respErr_d  = 1'b1;
      flagsUpd_d = 1'b0;
    end else if (aluOp_q == 5'b00101) begin
      respR_d = '0;
    end else if ((aluOp_q == 5'b01101 || aluOp_q == 5'b01110) && alu_div_invalid) begin
      respErr_d  = 1'b1;
      flagsUpd_d = 1'b0;
    end
  end

  // A capture on the same edge as flags_clr takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      aluOp_q   <= '0;
      aluX_q    <= '0;
      aluY_q    <= '0;
      respR_q   <= '0;
      respErr_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      if (flags_clr)
        flags_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            aluOp_q <= cmd_opcode;
            aluX_q  <= cmd_x;
            aluY_q  <= cmd_y;
            cnt_q   <= cmdLat_d;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q     <= '0;
            respR_q   <= respR_d;
            respErr_q <= respErr_d;
            if (flagsUpd_d)
              flags_q <= {alu_n, alu_z, alu_c, alu_v};
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign alu_opcode = aluOp_q;
  assign alu_x      = aluX_q;
  assign alu_y      = aluY_q;
  assign resp_r     = respR_q;
  assign resp_err   = respErr_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU model driving alu_r and flags.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_opcode;
  logic [15:0] cmd_x, cmd_y;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_x, alu_y;
  logic [15:0] alu_r;
  logic        alu_n, alu_z, alu_c, alu_v, alu_div_invalid;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_r;
  logic        resp_err;
  logic [3:0]  flags;
  logic        flags_clr;

  int checkCount = 0;
  int passCount  = 0;

  alu_issue_ctrl #(.WIDTH(16), .LAT_BASIC(1), .LAT_MUL(2), .LAT_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_x(cmd_x), .cmd_y(cmd_y),
    .alu_opcode(alu_opcode), .alu_x(alu_x), .alu_y(alu_y),
    .alu_r(alu_r), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .alu_div_invalid(alu_div_invalid),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_r(resp_r), .resp_err(resp_err),
    .flags(flags), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: C on subtract/compare means borrow (x < y).
  always_comb begin
    logic [16:0] sum;
    sum             = 17'd0;
    alu_r           = alu_x;
    alu_c           = 1'b0;
    alu_v           = 1'b0;
    alu_div_invalid = 1'b0;
    case (alu_opcode)
      5'b00001: begin
        sum   = {1'b0, alu_x} + {1'b0, alu_y};
        alu_r = sum[15:0];
        alu_c = sum[16];
        alu_v = (alu_x[15] == alu_y[15]) && (alu_r[15] != alu_x[15]);
      end
      5'b00010, 5'b00101: begin
        alu_r = alu_x - alu_y;
        alu_c = alu_x < alu_y;
        alu_v = (alu_x[15] != alu_y[15]) && (alu_r[15] != alu_x[15]);
      end
      5'b00011: alu_r = alu_x * alu_y;
      5'b01101, 5'b01110: begin
        if (alu_y == 16'd0) begin
          alu_r           = 16'hFFFF;
          alu_div_invalid = 1'b1;
        end else begin
          alu_r = (alu_opcode == 5'b01101) ? alu_x / alu_y : alu_x % alu_y;
        end
      end
      default: alu_r = alu_x;
    endcase
    alu_n = alu_r[15];
    alu_z = (alu_r == 16'd0);
  end

  // Presents one command for one edge; caller must be in IDLE (sampled #1 after an edge).
  task automatic applyStimulus(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_x      = x;
    cmd_y      = y;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
  endtask

  // Counts edges after acceptance until resp_valid; -1 means it never came.
  task automatic waitResp(output int lat);
    lat = -1;
    for (int i = 0; i <= 20; i++) begin
      if (resp_valid) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_x      = '0;
    cmd_y      = '0;
    resp_ready = 1'b1;
    flags_clr  = 1'b0;
    #1;
    checkCount++; if ({resp_valid, resp_err, resp_r, flags} !== 22'd0) $display("[TB] FAIL reset_outputs: got rv=%b err=%b r=%h flags=%b want 0", resp_valid, resp_err, resp_r, flags); else passCount++;
    checkCount++; if ({alu_opcode, alu_x, alu_y} !== 37'd0) $display("[TB] FAIL reset_alu_regs: got op=%b x=%h y=%h want 0", alu_opcode, alu_x, alu_y); else passCount++;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkCount++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passCount++;
  endtask

  task automatic test_add;
    int lat;
    applyStimulus(5'b00001, 16'h7FFF, 16'h0001);
    waitResp(lat);
    checkCount++; if (lat !== 1) $display("[TB] FAIL add_latency: got %0d want 1", lat); else passCount++;
    checkCount++; if ({resp_r, resp_err} !== {16'h8000, 1'b0}) $display("[TB] FAIL add_result: got r=%h err=%b want r=8000 err=0", resp_r, resp_err); else passCount++;
    checkCount++; if (flags !== 4'b1001) $display("[TB] FAIL add_flags: got %b want 1001", flags); else passCount++;
    @(posedge clk); #1;
    checkCount++; if ({resp_valid, cmd_ready} !== 2'b01) $display("[TB] FAIL add_handshake: got rv=%b rdy=%b want rv=0 rdy=1", resp_valid, cmd_ready); else passCount++;
  endtask

  task automatic test_div;
    int lat;
    applyStimulus(5'b01101, 16'd100, 16'd7);
    waitResp(lat);
    checkCount++; if (lat !== 4) $display("[TB] FAIL div_latency: got %0d want 4", lat); else passCount++;
    checkCount++; if ({resp_r, resp_err, flags} !== {16'd14, 1'b0, 4'b0000}) $display("[TB] FAIL div_result: got r=%0d err=%b flags=%b want r=14 err=0 flags=0000", resp_r, resp_err, flags); else passCount++;
    @(posedge clk); #1;
    applyStimulus(5'b01101, 16'd100, 16'd0);
    waitResp(lat);
    checkCount++; if (lat !== 4) $display("[TB] FAIL div0_latency: got %0d want 4", lat); else passCount++;
    checkCount++; if ({resp_r, resp_err, flags} !== {16'hFFFF, 1'b1, 4'b0000}) $display("[TB] FAIL div0_result: got r=%h err=%b flags=%b want r=ffff err=1 flags=0000", resp_r, resp_err, flags); else passCount++;
    @(posedge clk); #1;
  endtask

  task automatic test_compare_undef;
    int lat;
    applyStimulus(5'b00101, 16'd5, 16'd5);
    waitResp(lat);
    checkCount++; if ({resp_r, resp_err, flags} !== {16'd0, 1'b0, 4'b0100}) $display("[TB] FAIL cmp_result: got r=%h err=%b flags=%b want r=0 err=0 flags=0100", resp_r, resp_err, flags); else passCount++;
    @(posedge clk); #1;
    applyStimulus(5'b10000, 16'h1234, 16'h5678);
    waitResp(lat);
    checkCount++; if (lat !== 1) $display("[TB] FAIL undef_latency: got %0d want 1", lat); else passCount++;
    checkCount++; if ({resp_r, resp_err, flags} !== {16'd0, 1'b1, 4'b0100}) $display("[TB] FAIL undef_result: got r=%h err=%b flags=%b want r=0 err=1 flags=0100", resp_r, resp_err, flags); else passCount++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    int badCycles;
    resp_ready = 1'b0;
    applyStimulus(5'b00001, 16'd2, 16'd3);
    waitResp(lat);
    checkCount++; if (lat !== 1) $display("[TB] FAIL bp_latency: got %0d want 1", lat); else passCount++;
    cmd_valid  = 1'b1;
    cmd_opcode = 5'b00001;
    cmd_x      = 16'd9;
    cmd_y      = 16'd1;
    badCycles  = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!(resp_valid === 1'b1 && resp_r === 16'd5 && resp_err === 1'b0 && cmd_ready === 1'b0 && alu_x === 16'd2))
        badCycles++;
    end
    checkCount++; if (badCycles !== 0) $display("[TB] FAIL bp_hold: got %0d unstable cycles want 0 (rv=%b r=%h rdy=%b x=%h)", badCycles, resp_valid, resp_r, cmd_ready, alu_x); else passCount++;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checkCount++; if ({resp_valid, cmd_ready, alu_x} !== {1'b0, 1'b1, 16'd2}) $display("[TB] FAIL bp_handshake: got rv=%b rdy=%b x=%h want rv=0 rdy=1 x=0002", resp_valid, cmd_ready, alu_x); else passCount++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkCount++; if ({cmd_ready, alu_x} !== {1'b0, 16'd9}) $display("[TB] FAIL bp_accept_next: got rdy=%b x=%h want rdy=0 x=0009", cmd_ready, alu_x); else passCount++;
    waitResp(lat);
    checkCount++; if ({lat[7:0], resp_r} !== {8'd1, 16'd10}) $display("[TB] FAIL bp_next_result: got lat=%0d r=%0d want lat=1 r=10", lat, resp_r); else passCount++;
    @(posedge clk); #1;
  endtask

  task automatic test_flags_clr;
    applyStimulus(5'b00010, 16'd3, 16'd3);
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    checkCount++; if ({resp_valid, resp_r, flags} !== {1'b1, 16'd0, 4'b0100}) $display("[TB] FAIL clr_capture_wins: got rv=%b r=%h flags=%b want rv=1 r=0 flags=0100", resp_valid, resp_r, flags); else passCount++;
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    checkCount++; if (flags !== 4'b0000) $display("[TB] FAIL clr_next: got %b want 0000", flags); else passCount++;
  endtask

  task automatic test_reset_mid_wait;
    int lat;
    int sawResp;
    applyStimulus(5'b00001, 16'h7FFF, 16'h0001);
    waitResp(lat);
    @(posedge clk); #1;
    applyStimulus(5'b00011, 16'd3, 16'd4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkCount++; if ({resp_valid, cmd_ready, flags, resp_r, resp_err} !== {1'b0, 1'b1, 4'b0000, 16'd0, 1'b0}) $display("[TB] FAIL rst_mid_outputs: got rv=%b rdy=%b flags=%b r=%h err=%b want 0 1 0000 0 0", resp_valid, cmd_ready, flags, resp_r, resp_err); else passCount++;
    checkCount++; if ({alu_opcode, alu_x, alu_y} !== 37'd0) $display("[TB] FAIL rst_mid_alu_regs: got op=%b x=%h y=%h want 0", alu_opcode, alu_x, alu_y); else passCount++;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    sawResp = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) sawResp++;
    end
    checkCount++; if (sawResp !== 0) $display("[TB] FAIL rst_mid_no_resp: got %0d resp cycles want 0", sawResp); else passCount++;
    applyStimulus(5'b00001, 16'hFFFF, 16'h0001);
    waitResp(lat);
    checkCount++; if ({lat[7:0], resp_r, resp_err, flags} !== {8'd1, 16'd0, 1'b0, 4'b0110}) $display("[TB] FAIL rst_mid_add_after: got lat=%0d r=%h err=%b flags=%b want lat=1 r=0 err=0 flags=0110", lat, resp_r, resp_err, flags); else passCount++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_div();
    test_compare_undef();
    test_backpressure();
    test_flags_clr();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
